pipe_rca: RTL

PIPE_RCA -- requirements
Module: pipe_rca

---
 rtl/pipe_rca_pkg.sv | 12 +
 rtl/rca_chunk.sv | 29 ++
 rtl/pipe_rca.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_rca_pkg.sv
// Shared defaults for the pipelined ripple-carry adder and the stage-count derivation.
package pipe_rca_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;
    localparam int DEF_STAGES = DEF_WIDTH / DEF_CHUNK;

    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice; also exposes the carry into its MSB
// so the last pipeline stage can derive signed overflow.
module rca_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];
    assign cmsb = c[W - 1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor: CHUNK bits per stage, carry and unconsumed
// operand bits skewed stage to stage, one global enable driven by the output handshake.
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("pipe_rca: WIDTH must be a multiple of CHUNK");
    end

    logic                         en;
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            c_q;
    logic                         ovf_q;

    logic [STAGES-1:0]            v_d;
    logic [STAGES-1:0][WIDTH-1:0] a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_d;
    logic [STAGES-1:0]            c_d;

    logic [STAGES-1:0][CHUNK-1:0] cs;
    logic [STAGES-1:0]            co;
    logic [STAGES-1:0]            cm;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en       = !v_q[STAGES-1] || out_ready;
    assign in_ready = !rst && en;

    // Operand registers are kept shifted down so each stage always adds the low CHUNK bits.
    always_comb begin
        v_d    = '0;
        a_d    = '0;
        b_d    = '0;
        s_d    = '0;
        c_d    = '0;
        v_d[0] = in_valid;
        a_d[0] = a;
        b_d[0] = sub ? ~b : b;
        c_d[0] = sub ? 1'b1 : cin;
        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = v_q[k-1];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            c_d[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(
            .W(CHUNK)
        ) u_chunk (
            .a   (a_d[k][CHUNK-1:0]),
            .b   (b_d[k][CHUNK-1:0]),
            .cin (c_d[k]),
            .sum (cs[k]),
            .cout(co[k]),
            .cmsb(cm[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]                   <= v_d[k];
                a_q[k]                   <= a_d[k] >> CHUNK;
                b_q[k]                   <= b_d[k] >> CHUNK;
                s_q[k]                   <= s_d[k];
                s_q[k][k*CHUNK +: CHUNK] <= cs[k];
                c_q[k]                   <= co[k];
            end
            ovf_q <= co[STAGES-1] ^ cm[STAGES-1];
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
